// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// State encoding, requester count/index width and an index-to-one-hot helper.
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Circular priority picker: returns the first set, unmasked request bit
// found by searching start, start+1, ... (mod 4).
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  input  logic [NUM_REQ-1:0] mask,
  output logic [ID_W-1:0]    pick_id,
  output logic               pick_vld
);

  logic [NUM_REQ-1:0] cand_s;

  assign cand_s = req & ~mask;

  // Walk the offsets from farthest to nearest so the nearest candidate overwrites last.
  always_comb begin
    logic [ID_W-1:0] idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx      = start + ID_W'(i);
      pick_vld = cand_s[idx] ? 1'b1 : pick_vld;
      pick_id  = cand_s[idx] ? idx  : pick_id;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with registered one-hot grant, encoded
// grant index and valid flag; a grant is held until release or hold timeout.
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               gnt_vld_q, gnt_vld_d;

  logic               owner_req_s;
  logic               timeout_s;
  logic [ID_W-1:0]    pick_start_s;
  logic [NUM_REQ-1:0] pick_mask_s;
  logic [ID_W-1:0]    pick_id_s;
  logic               pick_vld_s;
  logic [CNT_W-1:0]   hold_inc_s;

  assign owner_req_s = req[gnt_id_q];
  assign timeout_s   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign hold_inc_s  = (hold_cnt_q == {CNT_W{1'b1}}) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);

  // While busy the search starts after the owner; on timeout the owner is masked out.
  assign pick_start_s = (state_q == ST_BUSY) ? gnt_id_q + 2'd1 : last_q + 2'd1;
  assign pick_mask_s  = (state_q == ST_BUSY && owner_req_s && timeout_s)
                        ? id_to_onehot(gnt_id_q) : '0;

  rr_pick_4 u_pick (
    .req      (req),
    .start    (pick_start_s),
    .mask     (pick_mask_s),
    .pick_id  (pick_id_s),
    .pick_vld (pick_vld_s)
  );

  // Next-state, pointer, hold counter and grant computation.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    gnt_vld_d  = gnt_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_d    = ST_BUSY;
          gnt_d      = id_to_onehot(pick_id_s);
          gnt_id_d   = pick_id_s;
          gnt_vld_d  = 1'b1;
          hold_cnt_d = '0;
        end else begin
          state_d    = ST_IDLE;
          gnt_d      = '0;
          gnt_id_d   = '0;
          gnt_vld_d  = 1'b0;
          hold_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (owner_req_s && !timeout_s) begin
          hold_cnt_d = hold_inc_s;
        end else if (owner_req_s) begin
          // Timeout: hand over if anyone else waits, otherwise re-grant the owner.
          last_d     = gnt_id_q;
          hold_cnt_d = '0;
          if (pick_vld_s) begin
            gnt_d    = id_to_onehot(pick_id_s);
            gnt_id_d = pick_id_s;
          end else begin
            gnt_d    = gnt_q;
            gnt_id_d = gnt_id_q;
          end
        end else begin
          last_d     = gnt_id_q;
          hold_cnt_d = '0;
          if (pick_vld_s) begin
            gnt_d    = id_to_onehot(pick_id_s);
            gnt_id_d = pick_id_s;
          end else begin
            state_d   = ST_IDLE;
            gnt_d     = '0;
            gnt_id_d  = '0;
            gnt_vld_d = 1'b0;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        last_d     = 2'd3;
        hold_cnt_d = '0;
        gnt_d      = '0;
        gnt_id_d   = '0;
        gnt_vld_d  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers; reset points the search at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      gnt_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      gnt_vld_q  <= gnt_vld_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4 with MAX_HOLD=4.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0000, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got gnt=%b id=%0d vld=%b, want 0000/0/0", gnt, gnt_id, gnt_vld);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({gnt, gnt_id, gnt_vld} !== {4'b0000, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got gnt=%b id=%0d vld=%b, want 0000/0/0", i, gnt, gnt_id, gnt_vld);
      end
    end
  endtask

  task automatic test_handoff();
    req = 4'b1010;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0010, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL first_grant: got gnt=%b id=%0d vld=%b, want 0010/1/1", gnt, gnt_id, gnt_vld);
    end
    req = 4'b1000;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b1000, 2'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_bubble: got gnt=%b id=%0d vld=%b, want 1000/3/1", gnt, gnt_id, gnt_vld);
    end
    req = 4'b0000;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0000, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL release_idle: got gnt=%b id=%0d vld=%b, want 0000/0/0", gnt, gnt_id, gnt_vld);
    end
  endtask

  // last=3 here, so all-request rotation starts at 0; each owner held 4 cycles.
  task automatic test_timeout_rotation();
    logic [1:0] order [5];
    logic [3:0] exp_g;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << order[k];
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if ({gnt, gnt_id, gnt_vld} !== {exp_g, order[k], 1'b1}) begin
          n_fail++;
          $display("FAIL rotate_k%0d_c%0d: got gnt=%b id=%0d vld=%b, want %b/%0d/1",
                   k, c, gnt, gnt_id, gnt_vld, exp_g, order[k]);
        end
        tick();
      end
    end
    // now owner 1 after the fifth timeout
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0010, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL rotate_after: got gnt=%b id=%0d vld=%b, want 0010/1/1", gnt, gnt_id, gnt_vld);
    end
    req = 4'b0000;
    tick();
  endtask

  // Lone requester regranted on timeout; a late arrival reveals the counter restarted.
  task automatic test_self_regrant();
    req = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if ({gnt, gnt_id, gnt_vld} !== {4'b0100, 2'd2, 1'b1}) begin
        n_fail++;
        $display("FAIL regrant_cycle%0d: got gnt=%b id=%0d vld=%b, want 0100/2/1", i, gnt, gnt_id, gnt_vld);
      end
      if (i == 9) req = 4'b0101;
    end
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0001, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL regrant_handover: got gnt=%b id=%0d vld=%b, want 0001/0/1", gnt, gnt_id, gnt_vld);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_no_preempt();
    req = 4'b0010;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0010, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL owner1_grant: got gnt=%b id=%0d vld=%b, want 0010/1/1", gnt, gnt_id, gnt_vld);
    end
    req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({gnt, gnt_id, gnt_vld} !== {4'b0010, 2'd1, 1'b1}) begin
        n_fail++;
        $display("FAIL no_preempt%0d: got gnt=%b id=%0d vld=%b, want 0010/1/1", i, gnt, gnt_id, gnt_vld);
      end
    end
    req = 4'b0001;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0001, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL after_release: got gnt=%b id=%0d vld=%b, want 0001/0/1", gnt, gnt_id, gnt_vld);
    end
    req = 4'b0000;
    tick();
  endtask

  // last=0 here, so req 1000 wins; after reset, search must restart at 0.
  task automatic test_reset_mid_grant();
    req = 4'b1000;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b1000, 2'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL owner3_grant: got gnt=%b id=%0d vld=%b, want 1000/3/1", gnt, gnt_id, gnt_vld);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0000, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_drop: got gnt=%b id=%0d vld=%b, want 0000/0/0", gnt, gnt_id, gnt_vld);
    end
    #1;
    rst_n = 1'b1;
    req   = 4'b1001;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0001, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_at0: got gnt=%b id=%0d vld=%b, want 0001/0/1", gnt, gnt_id, gnt_vld);
    end
  endtask

  // Owner 0 held with req 1001; chain releases through 3 then wraps back to 0.
  task automatic test_back_to_back();
    req = 4'b1000;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b1000, 2'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_to3: got gnt=%b id=%0d vld=%b, want 1000/3/1", gnt, gnt_id, gnt_vld);
    end
    req = 4'b0011;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0001, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_wrap0: got gnt=%b id=%0d vld=%b, want 0001/0/1", gnt, gnt_id, gnt_vld);
    end
    req = 4'b0010;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0010, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_to1: got gnt=%b id=%0d vld=%b, want 0010/1/1", gnt, gnt_id, gnt_vld);
    end
    req = 4'b0000;
    tick();
    n_tests++;
    if ({gnt, gnt_id, gnt_vld} !== {4'b0000, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_idle: got gnt=%b id=%0d vld=%b, want 0000/0/0", gnt, gnt_id, gnt_vld);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_handoff();
    test_timeout_rotation();
    test_self_regrant();
    test_no_preempt();
    test_reset_mid_grant();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
